// File: rtl/bin_to_dec_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock) driving active-low 7-segment digits.
// Optional leading-zero blanking is enabled by defining BIN_TO_DEC_BLANK_EN.
module bin_to_dec_seq #(
   parameter int WIDTH  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [WIDTH-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic                  ovf,
   output logic [4*DIGITS-1:0]   bcd,
   output logic [7*DIGITS-1:0]   hex
);

   localparam int SW = 4*DIGITS + WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic {IDLE, CONV} state_t;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Add-3 correction on every BCD digit field; binary part below is untouched.
   function automatic logic [SW-1:0] dabble_adjust(input logic [SW-1:0] s);
      logic [SW-1:0] r;
      logic [3:0]    d;
      r = s;
      for (int i = 0; i < DIGITS; i++) begin
         d = s[WIDTH+4*i +: 4];
         if (d >= 4'd5)
            r[WIDTH+4*i +: 4] = d + 4'd3;
      end
      return r;
   endfunction

   function automatic logic [7*DIGITS-1:0] reset_hex();
      logic [7*DIGITS-1:0] h;
      for (int i = 0; i < DIGITS; i++) begin
`ifdef BIN_TO_DEC_BLANK_EN
         h[7*i +: 7] = (i == 0) ? seg7(4'd0) : SEG_BLANK;
`else
         h[7*i +: 7] = seg7(4'd0);
`endif
      end
      return h;
   endfunction

   localparam logic [7*DIGITS-1:0] RST_HEX = reset_hex();

   state_t              state_q, state_d;
   logic [SW-1:0]       sr_q;
   logic [CW-1:0]       cnt_q;
   logic                ovf_acc_q;

   logic [SW-1:0]       adj;
   logic [SW-1:0]       step;
   logic                carry;
   logic                last;
   logic                accept;
   logic                ovf_next;
   logic [4*DIGITS-1:0] bcd_next;
   logic [7*DIGITS-1:0] hex_next;
   logic                lead;
   logic [3:0]          dig;

   assign busy = (state_q == CONV);

   always_comb begin
      state_d  = state_q;
      adj      = dabble_adjust(sr_q);
      step     = {adj[SW-2:0], 1'b0};
      carry    = adj[SW-1];
      accept   = (state_q == IDLE) && start;
      last     = (state_q == CONV) && (cnt_q == CW'(1));
      ovf_next = ovf_acc_q | carry;
      bcd_next = step[SW-1 -: 4*DIGITS];

      case (state_q)
         IDLE:    if (start) state_d = CONV;
         CONV:    if (last)  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Segment encoding of the result about to be registered; the dash overrides everything.
   always_comb begin
      hex_next = '0;
      lead     = 1'b1;
      dig      = '0;
      for (int i = DIGITS-1; i >= 0; i--) begin
         dig = bcd_next[4*i +: 4];
`ifdef BIN_TO_DEC_BLANK_EN
         if (lead && (i > 0) && (dig == 4'd0)) begin
            hex_next[7*i +: 7] = SEG_BLANK;
         end else begin
            hex_next[7*i +: 7] = seg7(dig);
            lead = 1'b0;
         end
`else
         hex_next[7*i +: 7] = seg7(dig);
         lead = 1'b0;
`endif
         if (ovf_next)
            hex_next[7*i +: 7] = SEG_DASH;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         done    <= 1'b0;
         ovf     <= 1'b0;
         bcd     <= '0;
         hex     <= RST_HEX;
      end else begin
         state_q <= state_d;
         done    <= last;
         if (last) begin
            bcd <= bcd_next;
            hex <= hex_next;
            ovf <= ovf_next;
         end
      end
   end

   // Working register, bit counter and carry-out accumulator; only meaningful while converting.
   always_ff @(posedge clk) begin
      if (accept) begin
         sr_q      <= {{(4*DIGITS){1'b0}}, bin};
         cnt_q     <= CW'(WIDTH);
         ovf_acc_q <= 1'b0;
      end else if (state_q == CONV) begin
         sr_q      <= step;
         cnt_q     <= cnt_q - CW'(1);
         ovf_acc_q <= ovf_next;
      end
   end

endmodule

// File: tb/tb_bin_to_dec_seq.sv
// Self-checking bench for bin_to_dec_seq: arithmetic reference model, per-cycle compare, directed and random stimulus.
module tb_bin_to_dec_seq;
   localparam int W = 8;
   localparam int D = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [W-1:0]  bin = '0;
   logic          busy, done, ovf;
   logic [4*D-1:0] bcd;
   logic [7*D-1:0] hex;

   logic          start2 = 1'b0;
   logic [W-1:0]  bin2 = '0;
   logic          busy2, done2, ovf2;
   logic [7:0]    bcd2;
   logic [13:0]   hex2;

   int vectors = 0;
   int miscompares = 0;

   bin_to_dec_seq #(.WIDTH(W), .DIGITS(D)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .bin(bin),
      .busy(busy), .done(done), .ovf(ovf), .bcd(bcd), .hex(hex));

   bin_to_dec_seq #(.WIDTH(W), .DIGITS(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin2),
      .busy(busy2), .done(done2), .ovf(ovf2), .bcd(bcd2), .hex(hex2));

   always #5 clk = ~clk;

   function automatic logic [6:0] segf(int d);
      case (d)
         0: return 7'b1000000;  1: return 7'b1111001;
         2: return 7'b0100100;  3: return 7'b0110000;
         4: return 7'b0011001;  5: return 7'b0010010;
         6: return 7'b0000010;  7: return 7'b1111000;
         8: return 7'b0000000;  default: return 7'b0010000;
      endcase
   endfunction

   function automatic int pow10(int n);
      int p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [63:0] exp_bcd(int v, int nd);
      logic [63:0] r = '0;
      int x = v;
      for (int i = 0; i < nd; i++) begin
         r = r | (64'(x % 10) << (4*i));
         x = x / 10;
      end
      return r;
   endfunction

   function automatic logic [63:0] exp_hex(int v, int nd);
      logic [63:0] r = '0;
      logic [6:0]  s;
      for (int i = 0; i < nd; i++) begin
         if (v >= pow10(nd))
            s = 7'b0111111;
`ifdef BIN_TO_DEC_BLANK_EN
         else if (i > 0 && v < pow10(i))
            s = 7'b1111111;
`endif
         else
            s = segf((v / pow10(i)) % 10);
         r = r | (64'(s) << (7*i));
      end
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: an accepted start yields the arithmetic result W edges later.
   int          m_rem;
   int          m_val;
   logic        m_done, m_ovf;
   logic [63:0] m_bcd, m_hex;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_rem  <= 0;
         m_val  <= 0;
         m_done <= 1'b0;
         m_ovf  <= 1'b0;
         m_bcd  <= '0;
         m_hex  <= exp_hex(0, D);
      end else if (m_rem == 0) begin
         m_done <= 1'b0;
         if (start) begin
            m_rem <= W;
            m_val <= int'(bin);
         end
      end else begin
         m_rem <= m_rem - 1;
         if (m_rem == 1) begin
            m_done <= 1'b1;
            m_bcd  <= exp_bcd(m_val, D);
            m_hex  <= exp_hex(m_val, D);
            m_ovf  <= (m_val >= pow10(D));
         end else begin
            m_done <= 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check("busy", busy, (m_rem != 0));
      check("done", done, m_done);
      check("ovf",  ovf,  m_ovf);
      check("bcd",  bcd,  m_bcd);
      check("hex",  hex,  m_hex);
      check("busy_and_done", busy & done, 1'b0);
   end

   task automatic wait_done(output int cycles);
      cycles = 0;
      for (int i = 0; i < 4*W; i++) begin
         @(posedge clk); #1;
         if (done) begin
            cycles = i + 1;
            return;
         end
      end
      check("done_timeout", 1'b0, 1'b1);
   endtask

   task automatic wait_done2(output int cycles);
      cycles = 0;
      for (int i = 0; i < 4*W; i++) begin
         @(posedge clk); #1;
         if (done2) begin
            cycles = i + 1;
            return;
         end
      end
      check("done2_timeout", 1'b0, 1'b1);
   endtask

   task automatic convert(input int v, output int cycles);
      @(negedge clk); start = 1'b1; bin = W'(v);
      @(negedge clk); start = 1'b0;
      wait_done(cycles);
   endtask

   task automatic convert2(input int v, output int cycles);
      @(negedge clk); start2 = 1'b1; bin2 = W'(v);
      @(negedge clk); start2 = 1'b0;
      wait_done2(cycles);
   endtask

   logic [7*D-1:0] rst_hex_lit;
   logic [7*D-1:0] hex7_lit;
   int n;

   initial begin
`ifdef BIN_TO_DEC_BLANK_EN
      rst_hex_lit = {7'b1111111, 7'b1111111, 7'b1000000};
      hex7_lit    = {7'b1111111, 7'b1111111, 7'b1111000};
`else
      rst_hex_lit = {7'b1000000, 7'b1000000, 7'b1000000};
      hex7_lit    = {7'b1000000, 7'b1000000, 7'b1111000};
`endif
      repeat (3) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_ovf",  ovf,  1'b0);
      check("rst_bcd",  bcd,  12'h000);
      check("rst_hex",  hex,  rst_hex_lit);
      check("rst_bcd2", bcd2, 8'h00);
      rst_n = 1'b1;

      convert(255, n);
      check("lat_255", n, W);
      check("bcd_255", bcd, 12'h255);
      check("hex_255", hex, {7'b0100100, 7'b0010010, 7'b0010010});
      check("ovf_255", ovf, 1'b0);

      convert(7, n);
      check("bcd_7", bcd, 12'h007);
      check("hex_7", hex, hex7_lit);

      // start held and bin changed mid-conversion must be ignored
      @(negedge clk); start = 1'b1; bin = 8'd42;
      repeat (3) begin @(negedge clk); start = 1'b1; bin = 8'd99; end
      @(negedge clk); start = 1'b0;
      wait_done(n);
      check("bcd_42", bcd, 12'h042);
      @(negedge clk); start = 1'b1; bin = 8'd99;
      @(negedge clk); start = 1'b0;
      wait_done(n);
      check("lat_b2b", n, W);
      check("bcd_99", bcd, 12'h099);

      // reset 4 cycles into a conversion of 200
      @(negedge clk); start = 1'b1; bin = 8'd200;
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_busy", busy, 1'b0);
      check("abort_bcd",  bcd,  12'h000);
      check("abort_hex",  hex,  rst_hex_lit);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      convert(13, n);
      check("bcd_13", bcd, 12'h013);

      // two-digit instance: overflow then recovery
      convert2(100, n);
      check("ovf2_100", ovf2, 1'b1);
      check("bcd2_100", bcd2, 8'h00);
      check("hex2_100", hex2, {7'b0111111, 7'b0111111});
      convert2(99, n);
      check("ovf2_99", ovf2, 1'b0);
      check("bcd2_99", bcd2, 8'h99);
      check("hex2_99", hex2, {7'b0010000, 7'b0010000});

      // random traffic, including starts during conversion and on done cycles
      for (int i = 0; i < 1500; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 2) == 0);
         bin   = W'($urandom);
      end
      @(negedge clk); start = 1'b0;
      repeat (W + 3) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
